spi_target: RTL and testbench

SPI mode-0 responder (target) for the far end of the `spi` master link. It models the register-mapped peripherals the top level talks to, such as the temperature sensor. It runs on the system clock, oversamples SCK/CS/MOSI, decodes command/address/data bytes into an internal register bank, and shifts register contents back on MISO. It serves as the on-board bring-up stand-in for the sensor and as the responder in master-side benches.

---
 rtl/spi_target_pkg.sv | 23 ++
 rtl/spi_target_sync_edge.sv | 34 +++
 rtl/spi_target.sv | 196 +++++++++++++++++++
 tb/tb_spi_target.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_target_pkg
// Description : Shared constants for the SPI mode-0 register-bank responder:
//               FSM state encoding and command-byte layout.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_target_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    // Command byte: bit 7 selects write (1) or read (0)
    localparam int CMD_WRITE_BIT = 7;

    // Minimum ratio of system clock to SCK for reliable edge detection
    localparam int MIN_OVERSAMPLE = 4;

endpackage : spi_target_pkg
`default_nettype wire

// File: rtl/spi_target_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Two-flop synchronizer for an asynchronous pin, followed by a
//               history flop that yields single-cycle rise/fall pulses on the
//               synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge (
    input  logic clk,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronizer and edge history; left unreset so a reset asserted while
    // the pin is active does not fabricate an edge afterwards.
    always_ff @(posedge clk) begin
        meta <= async_in;
        sync <= meta;
        prev <= sync;
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module      : spi_target
// Description : SPI mode-0 target with an internal 8-bit register bank.
//               Oversamples SCK/CS/MOSI on the system clock, decodes a
//               command byte (R/W + start address) followed by data bytes
//               with post-incrementing, wrapping address, and shifts register
//               contents back on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_target
    import spi_target_pkg::*;
#(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic                        sys_clk_pin,
    input  logic                        rst,
    input  logic                        sck,
    input  logic                        cs_n,
    input  logic                        mosi,
    output logic                        miso,
    output logic                        miso_oe,
    input  logic                        host_we,
    input  logic [$clog2(NUM_REGS)-1:0] host_addr,
    input  logic [7:0]                  host_wdata,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic [7:0]                  wr_data,
    output logic                        frame_done
);

    localparam int AW = $clog2(NUM_REGS);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic cs_n_level;
    logic cs_rise;
    logic cs_fall;
    logic mosi_meta;
    logic mosi_sync;

    spi_sync_edge u_sck_sync (
        .clk      (sys_clk_pin),
        .async_in (sck),
        .level    (sck_level_unused),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    spi_sync_edge u_cs_sync (
        .clk      (sys_clk_pin),
        .async_in (cs_n),
        .level    (cs_n_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Plain two-flop synchronizer for MOSI; its output lines up with the
    // cycle in which the SCK rise is detected.
    always_ff @(posedge sys_clk_pin) begin
        mosi_meta <= mosi;
        mosi_sync <= mosi_meta;
    end

    // ------------------------------------------------------------------
    // State and datapath
    // ------------------------------------------------------------------
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_shift;
    logic [7:0]    tx_shift;
    logic [AW-1:0] addr;
    logic          blocked;
    logic [7:0]    regs [NUM_REGS];

    logic [7:0]    rx_next;
    logic          byte_done;
    logic          spi_we;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;

    assign rx_next   = {rx_shift[6:0], mosi_sync};
    assign byte_done = (state != ST_IDLE) && !cs_rise && sck_rise && (bit_cnt == 3'd7);
    assign spi_we    = byte_done && (state == ST_WDATA);
    assign addr_inc  = addr + AW'(1);
    // In CMD the next byte's address comes straight from the command byte
    assign load_addr = (state == ST_CMD) ? rx_next[AW-1:0] : addr_inc;
    assign load_data = regs[load_addr];

    // Register bank: host writes first, SPI write last so it wins a collision
    always_ff @(posedge sys_clk_pin) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
            if (spi_we) begin
                regs[addr] <= rx_next;
            end
        end
    end

    // Frame FSM, shift registers, MISO driver and status pulses
    always_ff @(posedge sys_clk_pin) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            addr       <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            frame_done <= 1'b0;
            // A frame interrupted by reset stays locked out until CS is
            // released and asserted again.
            blocked    <= ~cs_n_level;
        end else begin
            wr_strobe  <= 1'b0;
            frame_done <= 1'b0;
            if (cs_n_level) begin
                blocked <= 1'b0;
            end

            if (cs_rise) begin
                state      <= ST_IDLE;
                bit_cnt    <= 3'd0;
                miso_oe    <= 1'b0;
                frame_done <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall && !blocked) begin
                            state    <= ST_CMD;
                            bit_cnt  <= 3'd0;
                            miso_oe  <= 1'b1;
                            // Bit 7 goes out now; the first SCK fall must
                            // present bit 6, so the shifter starts pre-shifted.
                            miso     <= IDLE_BYTE[7];
                            tx_shift <= {IDLE_BYTE[6:0], 1'b0};
                        end
                    end
                    default: begin
                        if (sck_fall) begin
                            miso     <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                        if (sck_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            case (state)
                                ST_CMD: begin
                                    addr <= rx_next[AW-1:0];
                                    if (rx_next[CMD_WRITE_BIT]) begin
                                        state    <= ST_WDATA;
                                        tx_shift <= IDLE_BYTE;
                                    end else begin
                                        state    <= ST_RDATA;
                                        tx_shift <= load_data;
                                    end
                                end
                                ST_WDATA: begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= addr;
                                    wr_data   <= rx_next;
                                    addr      <= addr_inc;
                                    tx_shift  <= IDLE_BYTE;
                                end
                                default: begin
                                    addr     <= addr_inc;
                                    tx_shift <= load_data;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule : spi_target
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_target
// Description : Directed self-checking bench for spi_target (NUM_REGS = 8,
//               SCK = system clock / 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       host_we;
    logic [2:0] host_addr;
    logic [7:0] host_wdata;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;

    always #5 clk = ~clk;

    spi_target #(
        .NUM_REGS  (8),
        .RESET_VAL (8'h00),
        .IDLE_BYTE (8'h00)
    ) dut (
        .sys_clk_pin (clk),
        .rst         (rst),
        .sck         (sck),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [10:0] strobe_q [$];
    int          frame_cnt = 0;

    // Record SPI write strobes and frame-done pulses away from the clock edge
    always @(negedge clk) begin
        if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});
        if (frame_done) frame_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_strobe(input string tag, input logic [10:0] exp);
        logic [10:0] got;
        got = (strobe_q.size() > 0) ? strobe_q.pop_front() : 11'h7FF;
        check(tag, {21'd0, got}, {21'd0, exp});
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: drive MOSI while SCK low, sample MISO just before rise.
    // With collide set, host_we is pulsed in the cycle the DUT acts on the
    // final rise (3 cycles after the pin edge).
    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit collide,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            wait_neg(4);
            rx[i] = miso;
            sck = 1'b1;
            if (collide && i == 0) begin
                wait_neg(2);
                host_we = 1'b1;
                wait_neg(1);
                host_we = 1'b0;
                wait_neg(1);
            end else begin
                wait_neg(4);
            end
            sck = 1'b0;
        end
    endtask

    task automatic begin_frame();
        cs_n = 1'b0;
        wait_neg(8);
    endtask

    task automatic end_frame();
        wait_neg(8);
        cs_n = 1'b1;
        wait_neg(8);
    endtask

    logic [7:0] rx;
    int         fc0;

    initial begin
        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        host_we = 1'b0; host_addr = 3'd0; host_wdata = 8'h00;
        wait_neg(6);
        check("rst_miso",       {31'd0, miso},       32'd0);
        check("rst_miso_oe",    {31'd0, miso_oe},    32'd0);
        check("rst_wr_strobe",  {31'd0, wr_strobe},  32'd0);
        check("rst_wr_addr",    {29'd0, wr_addr},    32'd0);
        check("rst_wr_data",    {24'd0, wr_data},    32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        wait_neg(4);

        // Write 0x81, 0xA5, 0x3C
        fc0 = frame_cnt;
        begin_frame();
        check("t1_cs_oe", {31'd0, miso_oe}, 32'd1);
        spi_byte(8'h81, 8, 1'b0, rx); check("t1_cmd_miso", {24'd0, rx}, 32'h00);
        spi_byte(8'hA5, 8, 1'b0, rx); check("t1_wd0_miso", {24'd0, rx}, 32'h00);
        spi_byte(8'h3C, 8, 1'b0, rx);
        end_frame();
        check("t1_oe_off", {31'd0, miso_oe}, 32'd0);
        check("t1_nstrobe", strobe_q.size(), 32'd2);
        check_strobe("t1_strobe0", {3'd1, 8'hA5});
        check_strobe("t1_strobe1", {3'd2, 8'h3C});
        check("t1_frame_done", frame_cnt - fc0, 32'd1);

        // Read back from address 1
        fc0 = frame_cnt;
        begin_frame();
        spi_byte(8'h01, 8, 1'b0, rx); check("t2_cmd_miso", {24'd0, rx}, 32'h00);
        spi_byte(8'h00, 8, 1'b0, rx); check("t2_rd0", {24'd0, rx}, 32'hA5);
        spi_byte(8'h00, 8, 1'b0, rx); check("t2_rd1", {24'd0, rx}, 32'h3C);
        end_frame();
        check("t2_frame_done", frame_cnt - fc0, 32'd1);
        check("t2_no_strobe", strobe_q.size(), 32'd0);

        // Host write visible to SPI read
        host_addr = 3'd3; host_wdata = 8'h5A; host_we = 1'b1;
        wait_neg(1);
        host_we = 1'b0;
        begin_frame();
        spi_byte(8'h03, 8, 1'b0, rx); check("t3_cmd_miso", {24'd0, rx}, 32'h00);
        spi_byte(8'h00, 8, 1'b0, rx); check("t3_host_rd", {24'd0, rx}, 32'h5A);
        end_frame();

        // Address wrap 7 -> 0
        begin_frame();
        spi_byte(8'h87, 8, 1'b0, rx);
        spi_byte(8'h11, 8, 1'b0, rx);
        spi_byte(8'h22, 8, 1'b0, rx);
        end_frame();
        check_strobe("t4_strobe0", {3'd7, 8'h11});
        check_strobe("t4_strobe1", {3'd0, 8'h22});
        begin_frame();
        spi_byte(8'h07, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx); check("t4_rd7", {24'd0, rx}, 32'h11);
        spi_byte(8'h00, 8, 1'b0, rx); check("t4_rd0", {24'd0, rx}, 32'h22);
        end_frame();

        // Partial data byte discarded
        fc0 = frame_cnt;
        begin_frame();
        spi_byte(8'h84, 8, 1'b0, rx);
        spi_byte(8'h77, 8, 1'b0, rx);
        spi_byte(8'h99, 5, 1'b0, rx);
        end_frame();
        check("t5_nstrobe", strobe_q.size(), 32'd1);
        check_strobe("t5_strobe0", {3'd4, 8'h77});
        check("t5_frame_done", frame_cnt - fc0, 32'd1);
        begin_frame();
        spi_byte(8'h04, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx); check("t5_rd4", {24'd0, rx}, 32'h77);
        spi_byte(8'h00, 8, 1'b0, rx); check("t5_rd5_unchanged", {24'd0, rx}, 32'h00);
        end_frame();

        // Collision, same address: SPI wins
        host_addr = 3'd2; host_wdata = 8'hFF;
        begin_frame();
        spi_byte(8'h82, 8, 1'b0, rx);
        spi_byte(8'h0F, 8, 1'b1, rx);
        end_frame();
        check_strobe("t6_strobe", {3'd2, 8'h0F});
        begin_frame();
        spi_byte(8'h02, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx); check("t6_rd2", {24'd0, rx}, 32'h0F);
        end_frame();

        // Collision, different addresses: both land
        host_addr = 3'd6; host_wdata = 8'hC3;
        begin_frame();
        spi_byte(8'h85, 8, 1'b0, rx);
        spi_byte(8'h44, 8, 1'b1, rx);
        end_frame();
        check_strobe("t7_strobe", {3'd5, 8'h44});
        begin_frame();
        spi_byte(8'h05, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx); check("t7_rd5", {24'd0, rx}, 32'h44);
        spi_byte(8'h00, 8, 1'b0, rx); check("t7_rd6", {24'd0, rx}, 32'hC3);
        end_frame();

        // Reset in the middle of a read frame
        begin_frame();
        spi_byte(8'h01, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx); check("t8_rd1_pre", {24'd0, rx}, 32'hA5);
        spi_byte(8'h00, 3, 1'b0, rx);
        rst = 1'b1;
        wait_neg(2);
        rst = 1'b0;
        wait_neg(1);
        check("t8_rst_miso",    {31'd0, miso},    32'd0);
        check("t8_rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        spi_byte(8'hFF, 8, 1'b0, rx);
        spi_byte(8'hFF, 8, 1'b0, rx);
        check("t8_ignored_miso",    {31'd0, miso},    32'd0);
        check("t8_ignored_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("t8_ignored_strobe",  strobe_q.size(),  32'd0);
        end_frame();
        begin_frame();
        spi_byte(8'h01, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx); check("t8_rd1_reset", {24'd0, rx}, 32'h00);
        spi_byte(8'h00, 8, 1'b0, rx); check("t8_rd2_reset", {24'd0, rx}, 32'h00);
        end_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_spi_target
`default_nettype wire
